// File: rtl/memory_service_scheduler_pkg.sv
// Shared types and defaults for the memory service scheduler: FSM states,
// requester-index encoding and default tuning constants.
package mss_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, COOL} state_t;

    // Requester index: bit 3 = direction (0 write side, 1 read side), bits 2:0 = channel.
    localparam int IDX_W = 4;
    typedef logic [IDX_W-1:0] req_idx_t;
    typedef logic [2:0]       chan_t;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_BURST_LEN  = 32;
    localparam int DEF_LOW_WATER  = 128;
    localparam int DEF_HIGH_WATER = 1536;
    localparam int DEF_TIMEOUT    = 4096;

    function automatic logic idx_dir(input req_idx_t idx);
        return idx[3];
    endfunction

    function automatic chan_t idx_chan(input req_idx_t idx);
        return idx[2:0];
    endfunction

    function automatic req_idx_t make_idx(input logic dir, input chan_t chan);
        return {dir, chan};
    endfunction

endpackage

// File: rtl/memory_service_scheduler_if.sv
// Grant handshake between the scheduler (master) and the memory arbitrator (slave).
interface memory_service_scheduler_if;
    import mss_pkg::*;

    logic       grant_valid;
    logic       grant_ready;
    logic       grant_dir;
    chan_t      grant_chan;
    logic [7:0] grant_len;
    logic       xfer_done;
    logic       busy;

    modport master (
        output grant_valid, grant_dir, grant_chan, grant_len, busy,
        input  grant_ready, xfer_done
    );

    modport slave (
        input  grant_valid, grant_dir, grant_chan, grant_len, busy,
        output grant_ready, xfer_done
    );

endinterface

// File: rtl/memory_service_scheduler_rr_picker.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
module rr_picker #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_cand;

    // Scan from farthest to nearest so the closest set bit to the pointer wins last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = i_ptr + IW'(k);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_service_scheduler.sv
// Memory service scheduler: watches 16 tracking FIFOs, registers request and
// urgency vectors, and issues one round-robin burst grant at a time.
module memory_service_scheduler
    import mss_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LOW_WATER  = DEF_LOW_WATER,
    parameter int HIGH_WATER = DEF_HIGH_WATER,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] write_in_addrs,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] write_out_addrs,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] read_in_addrs,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] read_out_addrs,
    input  logic [NUM_CH-1:0]            ram_avail,
    input  logic [2*NUM_CH-1:0]          chan_enable,
    memory_service_scheduler_if.master   gnt
);

    localparam int REQ_N = 2 * NUM_CH;
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_A = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] LOW_A   = ADDR_WIDTH'(LOW_WATER);
    localparam logic [ADDR_WIDTH-1:0] HIGH_A  = ADDR_WIDTH'(HIGH_WATER);
    localparam logic [AGE_W-1:0]      AGE_MAX = AGE_W'(TIMEOUT);

    logic [ADDR_WIDTH-1:0] w_wfill  [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_rfill  [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_rspace [NUM_CH];
    logic [NUM_CH-1:0]     w_wreq, w_wurg, w_wflush, w_rreq, w_rurg;
    logic [AGE_W-1:0]      r_age [NUM_CH];

    logic [REQ_N-1:0]      r_req, r_urg;
    logic [NUM_CH-1:0]     r_flush;
    logic [7:0]            r_flush_len [NUM_CH];

    state_t                r_state;
    logic                  r_grant_valid, r_grant_dir, r_busy, r_cool;
    chan_t                 r_grant_chan;
    logic [7:0]            r_grant_len;
    req_idx_t              r_rr_ptr, r_win;

    req_idx_t              w_urg_idx, w_all_idx, w_win;
    logic                  w_urg_found, w_all_found, w_latch;
    logic [7:0]            w_win_len;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_wfill[gi]  = write_in_addrs[gi*ADDR_WIDTH +: ADDR_WIDTH]
                                - write_out_addrs[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_rfill[gi]  = read_in_addrs[gi*ADDR_WIDTH +: ADDR_WIDTH]
                                - read_out_addrs[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_rspace[gi] = '1 - w_rfill[gi];

            assign w_wurg[gi]   = chan_enable[gi] && (w_wfill[gi] >= HIGH_A);
            assign w_wflush[gi] = chan_enable[gi] && (w_wfill[gi] != '0)
                                && (w_wfill[gi] < BURST_A) && (r_age[gi] == AGE_MAX);
            assign w_wreq[gi]   = (chan_enable[gi] && (w_wfill[gi] >= BURST_A))
                                || w_wurg[gi] || w_wflush[gi];

            assign w_rreq[gi]   = chan_enable[NUM_CH+gi] && ram_avail[gi]
                                && (w_rspace[gi] >= BURST_A);
            assign w_rurg[gi]   = w_rreq[gi] && (w_rfill[gi] < LOW_A);

            // Age counter: time a partial write burst has waited; cleared when empty, disabled or granted.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_age[gi] <= '0;
                else if ((w_wfill[gi] == '0) || !chan_enable[gi]
                         || (w_latch && (w_win == make_idx(1'b0, chan_t'(gi)))))
                    r_age[gi] <= '0;
                else if (r_age[gi] != AGE_MAX)
                    r_age[gi] <= r_age[gi] + 1'b1;
            end

            // Keep the flush length alongside the registered request so the grant matches it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_flush_len[gi] <= '0;
                else
                    r_flush_len[gi] <= w_wfill[gi][7:0];
            end
        end
    endgenerate

    // Register request, urgency and flush vectors every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req   <= '0;
            r_urg   <= '0;
            r_flush <= '0;
        end else begin
            r_req   <= {w_rreq, w_wreq};
            r_urg   <= {w_rurg, w_wurg};
            r_flush <= w_wflush;
        end
    end

    rr_picker #(.N(REQ_N), .IW(IDX_W)) u_pick_urg (
        .i_req  (r_urg),
        .i_ptr  (r_rr_ptr),
        .o_idx  (w_urg_idx),
        .o_found(w_urg_found)
    );

    rr_picker #(.N(REQ_N), .IW(IDX_W)) u_pick_all (
        .i_req  (r_req),
        .i_ptr  (r_rr_ptr),
        .o_idx  (w_all_idx),
        .o_found(w_all_found)
    );

    // Urgent requests pre-empt the normal round-robin order.
    assign w_win     = w_urg_found ? w_urg_idx : w_all_idx;
    assign w_latch   = (r_state == IDLE) && w_all_found;
    assign w_win_len = (!idx_dir(w_win) && r_flush[idx_chan(w_win)])
                     ? r_flush_len[idx_chan(w_win)] : 8'(BURST_LEN);

    // Grant FSM: latch a winner, hold it until accepted, wait for completion, then cool down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_dir   <= 1'b0;
            r_grant_chan  <= '0;
            r_grant_len   <= '0;
            r_busy        <= 1'b0;
            r_rr_ptr      <= '0;
            r_win         <= '0;
            r_cool        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_all_found) begin
                    r_state       <= GRANT;
                    r_grant_valid <= 1'b1;
                    r_grant_dir   <= idx_dir(w_win);
                    r_grant_chan  <= idx_chan(w_win);
                    r_grant_len   <= w_win_len;
                    r_win         <= w_win;
                end
                GRANT: if (gnt.grant_ready) begin
                    r_state       <= WAIT;
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b1;
                    r_rr_ptr      <= r_win + IDX_W'(1);
                end
                WAIT: if (gnt.xfer_done) begin
                    r_state <= COOL;
                    r_busy  <= 1'b0;
                    r_cool  <= 1'b0;
                end
                COOL: begin
                    r_cool <= 1'b1;
                    if (r_cool)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt.grant_valid = r_grant_valid;
    assign gnt.grant_dir   = r_grant_dir;
    assign gnt.grant_chan  = r_grant_chan;
    assign gnt.grant_len   = r_grant_len;
    assign gnt.busy        = r_busy;

endmodule

// File: tb/tb_memory_service_scheduler.sv
// Directed testbench for memory_service_scheduler.
module tb_memory_service_scheduler;

    localparam int NC = 8;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NC*AW-1:0] wi, wo, ri, ro;
    logic [NC-1:0]   ram_avail;
    logic [2*NC-1:0] chan_enable;

    int cmp_n = 0;
    int err_n = 0;

    memory_service_scheduler_if gif();

    memory_service_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .write_in_addrs (wi),
        .write_out_addrs(wo),
        .read_in_addrs  (ri),
        .read_out_addrs (ro),
        .ram_avail      (ram_avail),
        .chan_enable    (chan_enable),
        .gnt            (gif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_w(input int ch, input int inp, input int outp);
        wi[ch*AW +: AW] = AW'(inp);
        wo[ch*AW +: AW] = AW'(outp);
    endtask

    task automatic set_r(input int ch, input int inp, input int outp);
        ri[ch*AW +: AW] = AW'(inp);
        ro[ch*AW +: AW] = AW'(outp);
    endtask

    task automatic clear_all();
        wi = '0; wo = '0; ri = '0; ro = '0;
        ram_avail = '0;
        chan_enable = '1;
        gif.grant_ready = 1'b0;
        gif.xfer_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_grant(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (gif.grant_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (gif.grant_valid === 1'b1) ok = 1'b1;
        $display("grant ok=%0d dir=%0d chan=%0d len=%0d t=%0t", ok, gif.grant_dir, gif.grant_chan, gif.grant_len, $time);
    endtask

    task automatic accept();
        gif.grant_ready = 1'b1;
        tick(1);
        gif.grant_ready = 1'b0;
    endtask

    task automatic complete();
        gif.xfer_done = 1'b1;
        tick(1);
        gif.xfer_done = 1'b0;
    endtask

    function automatic logic [11:0] fields();
        return {gif.grant_dir, gif.grant_chan, gif.grant_len};
    endfunction

    task automatic test_reset();
        bit ok;
        clear_all();
        reset = 1'b0;
        tick(2);
        cmp_n++;
        if ({gif.grant_valid, gif.busy, fields()} !== 14'h0) begin
            err_n++;
            $display("FAIL reset_values: got valid=%0d busy=%0d fields=%h, want 0 0 000", gif.grant_valid, gif.busy, fields());
        end
        reset = 1'b1;
        tick(1);
        wait_grant(6, ok);
        cmp_n++;
        if (ok) begin
            err_n++;
            $display("FAIL reset_idle: got a grant with no requests, want none");
        end
    endtask

    task automatic test_flush();
        bit ok;
        bit early;
        do_reset();
        set_w(2, 40, 0);
        tick(1);
        cmp_n++;
        if (gif.grant_valid !== 1'b0) begin
            err_n++;
            $display("FAIL latency_n1: got valid=%0d, want 0", gif.grant_valid);
        end
        tick(1);
        cmp_n++;
        if (gif.grant_valid !== 1'b1 || fields() !== 12'h220) begin
            err_n++;
            $display("FAIL latency_n2: got valid=%0d fields=%h, want 1 220", gif.grant_valid, fields());
        end
        accept();
        cmp_n++;
        if (gif.busy !== 1'b1 || gif.grant_valid !== 1'b0) begin
            err_n++;
            $display("FAIL busy_rise: got busy=%0d valid=%0d, want 1 0", gif.busy, gif.grant_valid);
        end
        set_w(2, 40, 32);
        complete();
        cmp_n++;
        if (gif.busy !== 1'b0) begin
            err_n++;
            $display("FAIL busy_fall: got busy=%0d, want 0", gif.busy);
        end
        early = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (gif.grant_valid === 1'b1) early = 1'b1;
            tick(1);
        end
        cmp_n++;
        if (early) begin
            err_n++;
            $display("FAIL flush_early: got grant before timeout, want none");
        end
        wait_grant(300, ok);
        cmp_n++;
        if (!ok || fields() !== 12'h208) begin
            err_n++;
            $display("FAIL flush_grant: got ok=%0d fields=%h, want 1 208", ok, fields());
        end
        accept();
        set_w(2, 40, 40);
        complete();
    endtask

    task automatic test_rr();
        bit ok;
        logic [11:0] exp_f [4];
        exp_f = '{12'h020, 12'h320, 12'hD20, 12'hF20};
        do_reset();
        set_w(0, 32, 0);
        set_w(3, 32, 0);
        set_r(5, 200, 0);
        ram_avail[5] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                set_w(0, 64, 32);
                set_r(7, 200, 0);
                ram_avail[7] = 1'b1;
            end
            wait_grant(20, ok);
            cmp_n++;
            if (!ok || fields() !== exp_f[k]) begin
                err_n++;
                $display("FAIL rr_order_%0d: got ok=%0d fields=%h, want 1 %h", k, ok, fields(), exp_f[k]);
            end
            accept();
            if (k == 0) set_w(0, 32, 32);
            if (k == 1) set_w(3, 32, 32);
            if (k == 2) ram_avail[5] = 1'b0;
            if (k == 3) ram_avail[7] = 1'b0;
            complete();
        end
    endtask

    task automatic test_urgent();
        bit ok;
        do_reset();
        set_w(1, 32, 0);
        set_r(6, 10, 0);
        ram_avail[6] = 1'b1;
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'hE20) begin
            err_n++;
            $display("FAIL urgent_first: got ok=%0d fields=%h, want 1 e20", ok, fields());
        end
        accept();
        ram_avail[6] = 1'b0;
        complete();
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'h120) begin
            err_n++;
            $display("FAIL urgent_then_normal: got ok=%0d fields=%h, want 1 120", ok, fields());
        end
        accept();
        set_w(1, 32, 32);
        complete();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        set_r(1, 2046, 0);
        ram_avail[1] = 1'b1;
        set_w(4, 5, 2000);
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'h420) begin
            err_n++;
            $display("FAIL wrap_fill: got ok=%0d fields=%h, want 1 420", ok, fields());
        end
        accept();
        chan_enable[4] = 1'b0;
        complete();
        wait_grant(50, ok);
        cmp_n++;
        if (ok) begin
            err_n++;
            $display("FAIL read_full: got grant fields=%h, want none", fields());
        end
        set_w(0, 2047, 0);
        set_r(3, 200, 0);
        ram_avail[3] = 1'b1;
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'h020) begin
            err_n++;
            $display("FAIL full_write_urgent: got ok=%0d fields=%h, want 1 020", ok, fields());
        end
        accept();
        set_w(0, 0, 0);
        complete();
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'hB20) begin
            err_n++;
            $display("FAIL normal_after_urgent: got ok=%0d fields=%h, want 1 b20", ok, fields());
        end
        accept();
        ram_avail[3] = 1'b0;
        complete();
    endtask

    task automatic test_stall();
        bit ok;
        bit unstable;
        do_reset();
        set_w(2, 32, 0);
        wait_grant(20, ok);
        unstable = !ok;
        for (int i = 0; i < 50; i++) begin
            if (i == 25) chan_enable = '0;
            tick(1);
            if (gif.grant_valid !== 1'b1 || fields() !== 12'h220) unstable = 1'b1;
        end
        cmp_n++;
        if (unstable) begin
            err_n++;
            $display("FAIL stall_stable: got valid=%0d fields=%h, want 1 220 throughout", gif.grant_valid, fields());
        end
        accept();
        set_w(2, 32, 32);
        complete();
        tick(4);
        complete();
        gif.grant_ready = 1'b1;
        tick(3);
        gif.grant_ready = 1'b0;
        cmp_n++;
        if (gif.grant_valid !== 1'b0 || gif.busy !== 1'b0) begin
            err_n++;
            $display("FAIL idle_ignore: got valid=%0d busy=%0d, want 0 0", gif.grant_valid, gif.busy);
        end
        chan_enable = '1;
        set_w(5, 32, 0);
        tick(2);
        cmp_n++;
        if (gif.grant_valid !== 1'b1 || fields() !== 12'h520) begin
            err_n++;
            $display("FAIL idle_then_grant: got valid=%0d fields=%h, want 1 520", gif.grant_valid, fields());
        end
        accept();
        set_w(5, 32, 32);
        complete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        set_w(3, 32, 0);
        wait_grant(20, ok);
        accept();
        cmp_n++;
        if (!ok || gif.busy !== 1'b1) begin
            err_n++;
            $display("FAIL pre_reset_busy: got ok=%0d busy=%0d, want 1 1", ok, gif.busy);
        end
        set_w(1, 32, 0);
        #1;
        reset = 1'b0;
        #1;
        cmp_n++;
        if ({gif.grant_valid, gif.busy, fields()} !== 14'h0) begin
            err_n++;
            $display("FAIL async_reset: got valid=%0d busy=%0d fields=%h, want 0 0 000", gif.grant_valid, gif.busy, fields());
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        wait_grant(20, ok);
        cmp_n++;
        if (!ok || fields() !== 12'h120) begin
            err_n++;
            $display("FAIL post_reset_rr: got ok=%0d fields=%h, want 1 120", ok, fields());
        end
        accept();
        set_w(1, 32, 32);
        complete();
    endtask

    initial begin
        test_reset();
        test_flush();
        test_rr();
        test_urgent();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
